uart_prog_loader: RTL

- UART program loader upstream of the CPU's instruction and data memories.
- On a start request it holds the CPU in reset, then receives framed words over a serial line and writes them into imem/dmem.
- On a terminator frame it releases the CPU.
- Sits between the board UART pin/button and the memory write ports that the CPU top multiplexes with its normal datapath.

---
 rtl/uart_loader_pkg.sv | 42 ++++
 rtl/uart_rx_core.sv | 97 +++++++++
 rtl/uart_prog_loader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared FSM encodings, target codes and frame sizes for the UART program loader.
// Build option UART_LOADER_CHECKSUM_EN adds an XOR checksum byte to each data frame.
package uart_loader_pkg;

    typedef logic [3:0] ld_state_t;

    localparam ld_state_t StIdle = 4'd0;
    localparam ld_state_t StTgt  = 4'd1;
    localparam ld_state_t StAh   = 4'd2;
    localparam ld_state_t StAl   = 4'd3;
    localparam ld_state_t StB3   = 4'd4;
    localparam ld_state_t StB2   = 4'd5;
    localparam ld_state_t StB1   = 4'd6;
    localparam ld_state_t StB0   = 4'd7;
    localparam ld_state_t StCk   = 4'd8;
    localparam ld_state_t StWr   = 4'd9;
    localparam ld_state_t StDone = 4'd10;
    localparam ld_state_t StErr  = 4'd11;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t RxIdle  = 2'd0;
    localparam rx_state_t RxStart = 2'd1;
    localparam rx_state_t RxData  = 2'd2;
    localparam rx_state_t RxStop  = 2'd3;

    localparam logic [7:0] TGT_IMEM = 8'h00;
    localparam logic [7:0] TGT_DMEM = 8'h01;
    localparam logic [7:0] TGT_END  = 8'hFF;

`ifdef UART_LOADER_CHECKSUM_EN
    localparam int unsigned DATA_FRAME_BYTES = 8;
`else
    localparam int unsigned DATA_FRAME_BYTES = 7;
`endif
    localparam int unsigned END_FRAME_BYTES = 1;

    function automatic logic is_load_target(input logic [7:0] b);
        return (b == TGT_IMEM) || (b == TGT_DMEM);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle byte/error pulses.
module uart_rx_core
    import uart_loader_pkg::*;
#(
    parameter int unsigned DIV = 179
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] HalfMax = CntW'(DIV / 2 - 1);
    localparam logic [CntW-1:0] BitMax  = CntW'(DIV - 1);

    logic [1:0]      sync_q;
    logic            rx_prev_q;
    logic            rx;
    rx_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    assign rx = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RxIdle: begin
                cnt_d = '0;
                if (rx_prev_q && !rx) state_d = RxStart;
            end
            RxStart: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt_q == HalfMax) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (cnt_q == BitMax) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RxStop;
                end
            end
            RxStop: begin
                if (cnt_q == BitMax) begin
                    cnt_d   = '0;
                    state_d = RxIdle;
                    valid_d = rx;
                    err_d   = !rx;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            state_q   <= RxIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx_i};
            rx_prev_q <= rx;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = shift_q;
    assign frame_err_o  = err_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: holds the CPU in reset and writes framed words into imem/dmem.
// Build option UART_LOADER_CHECKSUM_EN appends and verifies an XOR checksum byte per data frame.
module uart_prog_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 23000000,
    parameter int unsigned BAUD        = 128000,
    parameter int unsigned ADDR_W      = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              uart_rx,
    output logic              cpu_rst_hold,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              prog_done,
    output logic              rx_err
);

    localparam int unsigned DIV = CLK_FREQ_HZ / BAUD;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx_core #(
        .DIV(DIV)
    ) u_rx_core (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (uart_rx),
        .byte_valid_o(byte_valid),
        .byte_data_o (byte_data),
        .frame_err_o (frame_err)
    );

    ld_state_t         state_q, state_d;
    logic              start_q;
    logic              start_edge;
    logic              in_frame;
    logic              tgt_dmem_q, tgt_dmem_d;
    logic [15:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]        ck_q, ck_d;
`endif

    assign start_edge = start && !start_q;
    assign in_frame   = state_q inside {StTgt, StAh, StAl, StB3, StB2, StB1, StB0, StCk};

    always_comb begin
        state_d    = state_q;
        tgt_dmem_d = tgt_dmem_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef UART_LOADER_CHECKSUM_EN
        ck_d       = ck_q;
        if (byte_valid) ck_d = (state_q == StTgt) ? byte_data : (ck_q ^ byte_data);
`endif
        if (start_edge) begin
            state_d = StTgt;
        end else if (state_q == StWr) begin
            state_d = StTgt;
        end else if (frame_err && in_frame) begin
            state_d = StErr;
        end else if (byte_valid) begin
            case (state_q)
                StTgt: begin
                    if (byte_data == TGT_END) begin
                        state_d = StDone;
                    end else if (is_load_target(byte_data)) begin
                        tgt_dmem_d = (byte_data == TGT_DMEM);
                        state_d    = StAh;
                    end else begin
                        state_d = StErr;
                    end
                end
                StAh: begin addr_d[15:8] = byte_data;  state_d = StAl; end
                StAl: begin addr_d[7:0]  = byte_data;  state_d = StB3; end
                StB3: begin data_d[31:24] = byte_data; state_d = StB2; end
                StB2: begin data_d[23:16] = byte_data; state_d = StB1; end
                StB1: begin data_d[15:8]  = byte_data; state_d = StB0; end
                StB0: begin
                    data_d[7:0] = byte_data;
`ifdef UART_LOADER_CHECKSUM_EN
                    state_d = StCk;
`else
                    // Commit on entry so wr_addr/wr_data are already stable during WR.
                    wr_addr_d = ADDR_W'(addr_d);
                    wr_data_d = data_d;
                    state_d   = StWr;
`endif
                end
`ifdef UART_LOADER_CHECKSUM_EN
                StCk: begin
                    if (byte_data == ck_q) begin
                        wr_addr_d = ADDR_W'(addr_q);
                        wr_data_d = data_q;
                        state_d   = StWr;
                    end else begin
                        state_d = StErr;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            tgt_dmem_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            ck_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            tgt_dmem_q <= tgt_dmem_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
`ifdef UART_LOADER_CHECKSUM_EN
            ck_q       <= ck_d;
`endif
        end
    end

    // DONE and ERR are left only by rst or a start edge, so the sticky flags follow the state.
    assign cpu_rst_hold = !(state_q inside {StIdle, StDone});
    assign imem_we      = (state_q == StWr) && !tgt_dmem_q;
    assign dmem_we      = (state_q == StWr) && tgt_dmem_q;
    assign prog_done    = (state_q == StDone);
    assign rx_err       = (state_q == StErr);
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;

endmodule
